fp_lsu_memory: RTL and testbench

FP_LSU_MEMORY -- requirements
Module: fp_lsu_memory

---
 rtl/rv32f_pkg.sv | 17 +
 rtl/fp_lsu_memory.sv | 124 ++++++++++++
 tb/tb_fp_lsu_memory.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32f_pkg.sv
// Shared types for the FP load/store unit: FSM state and fault cause encodings.
package rv32f_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_ERR   = 2'd3
    } fp_lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_LD_MISALIGN   = 2'd0,
        CAUSE_ST_MISALIGN   = 2'd1,
        CAUSE_ILLEGAL_WIDTH = 2'd2
    } fp_lsu_cause_t;

endpackage

// File: rtl/fp_lsu_memory.sv
// FP load/store memory stage: splits FLW/FSW/FLD/FSD into 32-bit bus beats and
// writes load results back to the FP register file one cycle after the last beat.
module fp_lsu_memory
    import rv32f_pkg::*;
#(
    parameter int FLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_dbl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [FLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [BUS_W-1:0]  mem_store,
    input  logic              mem_busy,
    input  logic [BUS_W-1:0]  mem_load,
    output logic              freg_w,
    output logic [4:0]        freg_idx,
    output logic [FLEN-1:0]   freg_wdata,
    output logic              exception,
    output logic [1:0]        exc_cause
);

    fp_lsu_state_t     state_q, state_d;
    fp_lsu_cause_t     cause_q, cause_d;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;   // zero-extended so the high word exists for either FLEN
    logic [4:0]        rd_q;
    logic              load_q, dbl_q;
    logic [BUS_W-1:0]  lo_q;
    logic              freg_w_q;
    logic [4:0]        freg_idx_q;
    logic [FLEN-1:0]   freg_wdata_q;

    logic            in_beat, beat_done, last_beat, accept, illegal, misalign, wb_fire;
    logic [FLEN-1:0] wb_data;

    assign in_beat   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign beat_done = in_beat && !mem_busy;
    assign last_beat = (state_q == S_BEAT1) || ((state_q == S_BEAT0) && !dbl_q);
    assign wb_fire   = beat_done && last_beat && load_q;
    assign accept    = (state_q == S_IDLE) && req_valid;
    assign illegal   = req_dbl && (FLEN == 32);
    assign misalign  = req_dbl ? (req_addr[2:0] != 3'b0) : (req_addr[1:0] != 2'b0);

    // Single-word loads are NaN-boxed; with FLEN=32 the truncation drops the box.
    assign wb_data = FLEN'(dbl_q ? {mem_load, lo_q} : {32'hFFFF_FFFF, mem_load});

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                if (illegal) begin
                    state_d = S_ERR;
                    cause_d = CAUSE_ILLEGAL_WIDTH;
                end else if (misalign) begin
                    state_d = S_ERR;
                    cause_d = req_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                end else begin
                    state_d = S_BEAT0;
                end
            end
            S_BEAT0: if (!mem_busy) state_d = dbl_q ? S_BEAT1 : S_IDLE;
            S_BEAT1: if (!mem_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            cause_q      <= CAUSE_LD_MISALIGN;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            load_q       <= 1'b0;
            dbl_q        <= 1'b0;
            lo_q         <= '0;
            freg_w_q     <= 1'b0;
            freg_idx_q   <= '0;
            freg_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            freg_w_q <= wb_fire;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= 64'(req_wdata);
                rd_q    <= req_rd;
                load_q  <= req_load;
                dbl_q   <= req_dbl;
            end
            if ((state_q == S_BEAT0) && beat_done && load_q) lo_q <= mem_load;
            if (wb_fire) begin
                freg_idx_q   <= rd_q;
                freg_wdata_q <= wb_data;
            end
        end
    end

    assign mem_ren   = in_beat && load_q;
    assign mem_wen   = in_beat && !load_q;
    assign mem_addr  = (state_q == S_BEAT0) ? addr_q :
                       (state_q == S_BEAT1) ? addr_q + ADDR_W'(4) : '0;
    assign mem_store = (state_q == S_BEAT0) ? wdata_q[31:0] :
                       (state_q == S_BEAT1) ? wdata_q[63:32] : '0;
    // Gated by reset so a held req_valid cannot leak out while nRST is low.
    assign busy      = nRST && (accept || (in_beat && !(beat_done && last_beat)));
    assign exception = (state_q == S_ERR);
    assign exc_cause = (state_q == S_ERR) ? cause_q : 2'b0;
    assign freg_w     = freg_w_q;
    assign freg_idx   = freg_idx_q;
    assign freg_wdata = freg_wdata_q;

endmodule

// File: tb/tb_fp_lsu_memory.sv
// Bench for fp_lsu_memory: FLEN=32 (lane 0) and FLEN=64 (lane 1) instances, each
// checked every cycle against a transaction-level model, plus literal directed cases.
module tb_fp_lsu_memory;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic        rv[2], rl[2], rdbl[2], mbusy[2];
    logic [31:0] raddr[2], mload[2];
    logic [63:0] rwd[2];
    logic [4:0]  rrd[2];
    logic        bsy[2], mren[2], mwen[2], fw[2], exc[2];
    logic [31:0] maddr[2], mst[2];
    logic [1:0]  ecause[2];
    logic [4:0]  fidx[2];
    logic [31:0] fwd32;
    logic [63:0] fwd64;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_en = 1'b0;

    fp_lsu_memory #(.FLEN(32)) u_d32 (
        .CLK(CLK), .nRST(nRST), .req_valid(rv[0]), .req_load(rl[0]), .req_dbl(rdbl[0]),
        .req_addr(raddr[0]), .req_wdata(rwd[0][31:0]), .req_rd(rrd[0]), .busy(bsy[0]),
        .mem_addr(maddr[0]), .mem_ren(mren[0]), .mem_wen(mwen[0]), .mem_store(mst[0]),
        .mem_busy(mbusy[0]), .mem_load(mload[0]), .freg_w(fw[0]), .freg_idx(fidx[0]),
        .freg_wdata(fwd32), .exception(exc[0]), .exc_cause(ecause[0])
    );

    fp_lsu_memory #(.FLEN(64)) u_d64 (
        .CLK(CLK), .nRST(nRST), .req_valid(rv[1]), .req_load(rl[1]), .req_dbl(rdbl[1]),
        .req_addr(raddr[1]), .req_wdata(rwd[1]), .req_rd(rrd[1]), .busy(bsy[1]),
        .mem_addr(maddr[1]), .mem_ren(mren[1]), .mem_wen(mwen[1]), .mem_store(mst[1]),
        .mem_busy(mbusy[1]), .mem_load(mload[1]), .freg_w(fw[1]), .freg_idx(fidx[1]),
        .freg_wdata(fwd64), .exception(exc[1]), .exc_cause(ecause[1])
    );

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got %h, want %h @%0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic set_req(input int g, input bit v, input bit ld, input bit dbl,
                           input logic [31:0] a, input logic [63:0] wd, input logic [4:0] rd);
        rv[g] = v; rl[g] = ld; rdbl[g] = dbl; raddr[g] = a; rwd[g] = wd; rrd[g] = rd;
    endtask

    for (genvar g = 0; g < 2; g++) begin : ln
        localparam int FL = (g == 0) ? 32 : 64;
        // Model: an operation is a list of nb word beats; bi is the beat being offered.
        bit          in_tx, err_now, m_ld, m_dbl, fw_exp;
        int          bi, nb;
        logic [31:0] m_addr;
        logic [63:0] m_wd, fw_data;
        logic [4:0]  m_rd, fw_idx;
        logic [1:0]  m_cause;
        logic [31:0] words[2];
        logic [63:0] fwd_g;
        logic        exp_busy;

        assign fwd_g = (g == 0) ? {32'h0, fwd32} : fwd64;

        initial forever begin
            @(posedge CLK or negedge nRST);
            if (!nRST) begin
                in_tx = 0; err_now = 0; fw_exp = 0; bi = 0; nb = 0;
            end else begin
                fw_exp = 0;
                if (err_now) begin
                    err_now = 0;
                end else if (in_tx) begin
                    if (!mbusy[g]) begin
                        words[bi] = mload[g];
                        bi++;
                        if (bi == nb) begin
                            in_tx = 0;
                            if (m_ld) begin
                                fw_exp = 1;
                                fw_idx = m_rd;
                                if (FL == 32)  fw_data = {32'h0, words[0]};
                                else if (m_dbl) fw_data = {words[1], words[0]};
                                else           fw_data = {32'hFFFF_FFFF, words[0]};
                            end
                        end
                    end
                end else if (rv[g]) begin
                    if (rdbl[g] && FL == 32) begin
                        err_now = 1; m_cause = 2'd2;
                    end else if (rdbl[g] ? (raddr[g][2:0] != 0) : (raddr[g][1:0] != 0)) begin
                        err_now = 1; m_cause = rl[g] ? 2'd0 : 2'd1;
                    end else begin
                        in_tx = 1; bi = 0; nb = rdbl[g] ? 2 : 1;
                        m_ld = rl[g]; m_dbl = rdbl[g]; m_addr = raddr[g]; m_wd = rwd[g]; m_rd = rrd[g];
                    end
                end
            end
        end

        initial forever begin
            @(negedge CLK);
            if (rand_en) begin
                mbusy[g] = ($urandom_range(0, 3) == 0);
                mload[g] = $urandom;
            end
            #1;
            if (rand_en && !bsy[g]) begin
                rv[g]    = ($urandom_range(0, 2) != 0);
                rl[g]    = 1'($urandom_range(0, 1));
                rdbl[g]  = 1'($urandom_range(0, 1));
                raddr[g] = 32'($urandom_range(0, 255) << 4) |
                           (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) :
                            ($urandom_range(0, 1) != 0) ? 32'd4 : 32'd0);
                rwd[g]   = {$urandom, $urandom};
                rrd[g]   = 5'($urandom);
            end
            #1;
            if (!nRST) begin
                chk("rst_outs", g, {bsy[g], mren[g], mwen[g], maddr[g], mst[g], fw[g], exc[g], ecause[g]}, 0);
                chk("rst_fwd", g, fwd_g, 0);
            end else begin
                exp_busy = (!in_tx && !err_now && rv[g]) || (in_tx && !(!mbusy[g] && bi == nb - 1));
                chk("busy", g, bsy[g], exp_busy);
                chk("mem_ren", g, mren[g], in_tx && m_ld);
                chk("mem_wen", g, mwen[g], in_tx && !m_ld);
                chk("mem_addr", g, maddr[g], in_tx ? m_addr + 32'(4 * bi) : 32'h0);
                chk("mem_store", g, mst[g], in_tx ? ((bi == 1) ? m_wd[63:32] : m_wd[31:0]) : 32'h0);
                chk("exception", g, exc[g], err_now);
                chk("exc_cause", g, ecause[g], err_now ? m_cause : 2'd0);
                chk("freg_w", g, fw[g], fw_exp);
                if (fw_exp) begin
                    chk("freg_idx", g, fidx[g], fw_idx);
                    chk("freg_wdata", g, fwd_g, fw_data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            set_req(i, 0, 0, 0, 0, 0, 0);
            mbusy[i] = 0; mload[i] = 0;
        end
        // Reset: a held request must not raise busy.
        rv[0] = 1;
        #3;
        chk("reset_busy", 0, bsy[0], 0);
        chk("reset_fw", 1, fw[1], 0);
        rv[0] = 0;
        @(negedge CLK); @(negedge CLK);
        nRST = 1;

        // FLW 0x100, FLEN=32
        @(negedge CLK); set_req(0, 1, 1, 0, 32'h100, 0, 5); mload[0] = 32'h3F80_0000;
        #3 chk("t44_busy_acc", 0, bsy[0], 1);
        @(negedge CLK); rv[0] = 0;
        #3 chk("t44_ren", 0, mren[0], 1); chk("t44_addr", 0, maddr[0], 32'h100); chk("t44_busy_last", 0, bsy[0], 0);
        @(negedge CLK);
        #3 chk("t44_fw", 0, fw[0], 1); chk("t44_fwd", 0, fwd32, 32'h3F80_0000);
        chk("t44_idx", 0, fidx[0], 5); chk("t44_ren_off", 0, mren[0], 0);
        @(negedge CLK);
        #3 chk("t44_fw_pulse", 0, fw[0], 0);

        // FSD 0x208 with 3-cycle stall in BEAT0, FLEN=64
        @(negedge CLK); set_req(1, 1, 0, 1, 32'h208, 64'h4009_21FB_5444_2D18, 3); mbusy[1] = 1;
        #3 chk("t45_busy_acc", 1, bsy[1], 1); chk("t45_wen_idle", 1, mwen[1], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #3 chk("t45_stall_addr", 1, maddr[1], 32'h208); chk("t45_stall_data", 1, mst[1], 32'h5444_2D18);
            chk("t45_stall_wen", 1, mwen[1], 1); chk("t45_stall_busy", 1, bsy[1], 1);
        end
        @(negedge CLK); mbusy[1] = 0;
        #3 chk("t45_b0_addr", 1, maddr[1], 32'h208); chk("t45_b0_busy", 1, bsy[1], 1);
        @(negedge CLK); rv[1] = 0;
        #3 chk("t45_b1_addr", 1, maddr[1], 32'h20C); chk("t45_b1_data", 1, mst[1], 32'h4009_21FB);
        chk("t45_b1_wen", 1, mwen[1], 1); chk("t45_b1_ren", 1, mren[1], 0); chk("t45_b1_busy", 1, bsy[1], 0);
        @(negedge CLK);
        #3 chk("t45_done_wen", 1, mwen[1], 0); chk("t45_no_fw", 1, fw[1], 0);

        // FLW NaN-boxing, FLEN=64
        @(negedge CLK); set_req(1, 1, 1, 0, 32'h10, 0, 9); mload[1] = 32'h4049_0FDB;
        @(negedge CLK); rv[1] = 0;
        #3 chk("t46_addr", 1, maddr[1], 32'h10); chk("t46_ren", 1, mren[1], 1);
        @(negedge CLK);
        #3 chk("t46_fw", 1, fw[1], 1); chk("t46_fwd", 1, fwd64, 64'hFFFF_FFFF_4049_0FDB);

        // Faults: misaligned FLD (lane 1), FSD on FLEN=32 (lane 0)
        @(negedge CLK); set_req(1, 1, 1, 1, 32'h104, 0, 2); set_req(0, 1, 0, 1, 32'h0, 64'h1234, 1);
        @(negedge CLK); rv[0] = 0; rv[1] = 0;
        #3 chk("t47_exc", 1, exc[1], 1); chk("t47_cause", 1, ecause[1], 0);
        chk("t47_strobes", 1, {mren[1], mwen[1]}, 0); chk("t47_busy", 1, bsy[1], 0);
        chk("t47_w_exc", 0, exc[0], 1); chk("t47_w_cause", 0, ecause[0], 2);
        @(negedge CLK);
        #3 chk("t47_exc_off", 1, exc[1], 0); chk("t47_w_exc_off", 0, exc[0], 0); chk("t47_no_fw", 1, fw[1], 0);

        // Randomized traffic on both lanes
        @(posedge CLK); rand_en = 1;
        repeat (3000) @(posedge CLK);
        rand_en = 0;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin rv[i] = 0; mbusy[i] = 0; end
        repeat (4) @(negedge CLK);

        // Reset during BEAT1 of FLD
        @(negedge CLK); set_req(1, 1, 1, 1, 32'h200, 0, 7); mload[1] = 32'h1111_1111;
        #3 chk("t48_busy_acc", 1, bsy[1], 1);
        @(negedge CLK);
        #3 chk("t48_b0_addr", 1, maddr[1], 32'h200);
        @(negedge CLK); mload[1] = 32'h2222_2222;
        #1 chk("t48_b1_addr", 1, maddr[1], 32'h204); chk("t48_b1_ren", 1, mren[1], 1);
        nRST = 0;
        #1 chk("t48_rst_ren", 1, mren[1], 0); chk("t48_rst_addr", 1, maddr[1], 0);
        chk("t48_rst_busy", 1, bsy[1], 0); chk("t48_rst_fw", 1, fw[1], 0);
        rv[1] = 0;
        @(negedge CLK); @(negedge CLK);
        nRST = 1;
        repeat (3) begin
            @(negedge CLK);
            #3 chk("t48_post_fw", 1, fw[1], 0); chk("t48_post_busy", 1, bsy[1], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
